// File: rtl/rf_wb_arbiter_pkg.sv
// Purpose: shared MIPS writeback definitions: register count, field widths, skid-buffer FSM encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rf_wb_arbiter_pkg;

  localparam int NUM_REGS = 32;
  localparam int REG_W    = $clog2(NUM_REGS);
  localparam int DATA_W   = 32;
  localparam int CNT_W    = REG_W + 1;  // holds 0..31 pending destinations

  // Skid-buffer occupancy for the multi-cycle result path.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } md_state_t;

  // One register-file write: destination plus data.
  typedef struct packed {
    logic [REG_W-1:0]  addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/rf_wb_arbiter_scoreboard.sv
// Purpose: tracks destinations of in-flight multi-cycle ops and raises decode stall on RAW/WAW hazards.
// Latency: stall is combinational; pending/pend_cnt update on the next rising edge.
// Backpressure: an issue blocked by stall does not set pending; the issuer must hold it.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   iss_valid, iss_reg  multi-cycle op issued this cycle and its destination
//   clr_valid, clr_reg  multi-cycle result is on the register-file write port this cycle
//   rd_reg1, rd_reg2    decode source registers
//   stall               decode must hold
//   pend_cnt            number of set pending bits
module rf_scoreboard
  import rf_wb_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             iss_valid,
  input  logic [REG_W-1:0] iss_reg,
  input  logic             clr_valid,
  input  logic [REG_W-1:0] clr_reg,
  input  logic [REG_W-1:0] rd_reg1,
  input  logic [REG_W-1:0] rd_reg2,
  output logic             stall,
  output logic [CNT_W-1:0] pend_cnt
);

  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] pending_nxt;
  logic                raw1;
  logic                raw2;
  logic                waw;
  logic                set_en;
  logic                clr_en;

  always_comb begin
    raw1 = (rd_reg1 != '0) && pending[rd_reg1];
    raw2 = (rd_reg2 != '0) && pending[rd_reg2];
    // The older write to iss_reg is landing this cycle, so re-issuing to the
    // same destination is not a WAW hazard; the new set then wins over the clear.
    waw  = iss_valid && pending[iss_reg] &&
           !(clr_valid && (clr_reg == iss_reg));
    stall = raw1 || raw2 || waw;

    set_en = iss_valid && (iss_reg != '0) && !stall;
    clr_en = clr_valid && (clr_reg != '0) && pending[clr_reg];

    pending_nxt = pending;
    if (clr_en) pending_nxt[clr_reg] = 1'b0;
    if (set_en) pending_nxt[iss_reg] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      pending <= pending_nxt;
    end
  end

  // set_en only fires on a bit that is clear or being cleared this cycle, so
  // +1/-1 bookkeeping stays equal to the population count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_cnt <= '0;
    end else begin
      case ({set_en, clr_en})
        2'b10:   pend_cnt <= pend_cnt + CNT_W'(1);
        2'b01:   pend_cnt <= pend_cnt - CNT_W'(1);
        default: pend_cnt <= pend_cnt;
      endcase
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Purpose: arbitrates the register-file write port between the pipeline WB stage and a multi-cycle unit.
// Latency: registered outputs, write appears one cycle after the winning request is sampled.
// Backpressure: pipeline WB always wins; md side sees md_ready low while its one-entry skid buffer is full.
//
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   wb_we, wb_reg, wb_data           pipeline WB request (never stalled)
//   md_valid, md_ready, md_reg, md_data  multi-cycle result handshake
//   iss_valid, iss_reg               multi-cycle op issued this cycle
//   rd_reg1, rd_reg2, stall          decode sources and hazard stall
//   regwrite, writereg, writedata    register-file write port
//   pend_cnt                         count of pending multi-cycle destinations
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_we,
  input  logic [REG_W-1:0]  wb_reg,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              md_valid,
  output logic              md_ready,
  input  logic [REG_W-1:0]  md_reg,
  input  logic [DATA_W-1:0] md_data,
  input  logic              iss_valid,
  input  logic [REG_W-1:0]  iss_reg,
  input  logic [REG_W-1:0]  rd_reg1,
  input  logic [REG_W-1:0]  rd_reg2,
  output logic              stall,
  output logic              regwrite,
  output logic [REG_W-1:0]  writereg,
  output logic [DATA_W-1:0] writedata,
  output logic [CNT_W-1:0]  pend_cnt
);

  md_state_t state;
  md_state_t state_nxt;
  wr_req_t   buf_q;
  wr_req_t   sel;
  logic      sel_vld;
  logic      sel_md;
  logic      md_accept;
  logic      md_wr_q;

  assign md_ready  = (state == ST_EMPTY);
  assign md_accept = md_valid && md_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sel_vld   = 1'b0;
    sel_md    = 1'b0;
    sel.addr  = wb_reg;
    sel.data  = wb_data;
    if (wb_we) begin
      sel_vld = 1'b1;
      if (md_accept) state_nxt = ST_FULL;
    end else if (state == ST_FULL) begin
      sel_vld   = 1'b1;
      sel_md    = 1'b1;
      sel       = buf_q;
      state_nxt = ST_EMPTY;
    end else if (md_accept) begin
      // Idle port: the accepted result bypasses the buffer.
      sel_vld  = 1'b1;
      sel_md   = 1'b1;
      sel.addr = md_reg;
      sel.data = md_data;
    end
  end

  // Buffer only loads when the md result loses to the pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q <= '0;
    end else if (wb_we && md_accept) begin
      buf_q.addr <= md_reg;
      buf_q.data <= md_data;
    end
  end

  // Register-0 writes are consumed but never raise regwrite.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regwrite  <= 1'b0;
      writereg  <= '0;
      writedata <= '0;
      md_wr_q   <= 1'b0;
    end else begin
      regwrite <= sel_vld && (sel.addr != '0);
      md_wr_q  <= sel_vld && sel_md && (sel.addr != '0);
      if (sel_vld) begin
        writereg  <= sel.addr;
        writedata <= sel.data;
      end
    end
  end

  // Pending clears while the md write is on the port, so dependent reads
  // stay stalled until the register file actually holds the value.
  rf_scoreboard u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .iss_valid (iss_valid),
    .iss_reg   (iss_reg),
    .clr_valid (md_wr_q),
    .clr_reg   (writereg),
    .rd_reg1   (rd_reg1),
    .rd_reg2   (rd_reg2),
    .stall     (stall),
    .pend_cnt  (pend_cnt)
  );

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_reg = '0;
  logic [31:0] wb_data = '0;
  logic        md_valid = 1'b0;
  logic        md_ready;
  logic [4:0]  md_reg = '0;
  logic [31:0] md_data = '0;
  logic        iss_valid = 1'b0;
  logic [4:0]  iss_reg = '0;
  logic [4:0]  rd_reg1 = '0;
  logic [4:0]  rd_reg2 = '0;
  logic        stall;
  logic        regwrite;
  logic [4:0]  writereg;
  logic [31:0] writedata;
  logic [5:0]  pend_cnt;

  always #5 clk = ~clk;

  rf_wb_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wb_we     (wb_we),
    .wb_reg    (wb_reg),
    .wb_data   (wb_data),
    .md_valid  (md_valid),
    .md_ready  (md_ready),
    .md_reg    (md_reg),
    .md_data   (md_data),
    .iss_valid (iss_valid),
    .iss_reg   (iss_reg),
    .rd_reg1   (rd_reg1),
    .rd_reg2   (rd_reg2),
    .stall     (stall),
    .regwrite  (regwrite),
    .writereg  (writereg),
    .writedata (writedata),
    .pend_cnt  (pend_cnt)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit mon_en = 1'b0;

  typedef struct {
    int          due;
    logic [4:0]  r;
    logic [31:0] d;
  } exp_t;

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
  } ent_t;

  // Reference model: writes expected on the port, md results waiting for the
  // port (at most one), the set of pending destinations, and the md write that
  // is on the port this cycle (which retires its destination).
  exp_t       exp_q[$];
  ent_t       mdq[$];
  bit         pend_m[32];
  bit         md_on_port;
  logic [4:0] md_port_reg;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every cycle the write port must carry exactly what the model
  // scheduled for this cycle, or nothing.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en && rst_n) begin
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        e = exp_q.pop_front();
        check("wr_en", {31'd0, regwrite}, 32'd1);
        check("wr_reg", {27'd0, writereg}, {27'd0, e.r});
        check("wr_data", writedata, e.d);
      end else begin
        check("wr_idle", {31'd0, regwrite}, 32'd0);
      end
    end
  end

  task automatic model_reset();
    mdq.delete();
    exp_q.delete();
    foreach (pend_m[i]) pend_m[i] = 1'b0;
    md_on_port  = 1'b0;
    md_port_reg = '0;
  endtask

  task automatic step(input bit we, input logic [4:0] wr, input logic [31:0] wd,
                      input bit mv, input logic [4:0] mr, input logic [31:0] md,
                      input bit iv, input logic [4:0] ir,
                      input logic [4:0] r1, input logic [4:0] r2);
    int         cnt;
    bit         clr;
    logic [4:0] clr_r;
    bit         exp_stall;
    ent_t       h;
    @(posedge clk);
    #1;
    wb_we = we;  wb_reg = wr;  wb_data = wd;
    md_valid = mv;  md_reg = mr;  md_data = md;
    iss_valid = iv;  iss_reg = ir;
    rd_reg1 = r1;  rd_reg2 = r2;
    #1;
    clr   = md_on_port && (md_port_reg != 0);
    clr_r = md_port_reg;
    exp_stall = (r1 != 0 && pend_m[r1]) || (r2 != 0 && pend_m[r2]) ||
                (iv && pend_m[ir] && !(clr && clr_r == ir));
    cnt = 0;
    foreach (pend_m[i]) if (pend_m[i]) cnt++;
    check("md_ready", {31'd0, md_ready}, {31'd0, mdq.size() == 0});
    check("stall", {31'd0, stall}, {31'd0, exp_stall});
    check("pend_cnt", {26'd0, pend_cnt}, cnt);
    // md results queue behind the pipeline; the oldest goes out when WB is idle.
    if (mv && mdq.size() == 0) mdq.push_back('{mr, md});
    md_on_port = 1'b0;
    if (we) begin
      if (wr != 0) exp_q.push_back('{cyc + 1, wr, wd});
    end else if (mdq.size() > 0) begin
      h = mdq.pop_front();
      if (h.r != 0) exp_q.push_back('{cyc + 1, h.r, h.d});
      md_on_port  = 1'b1;
      md_port_reg = h.r;
    end
    if (clr) pend_m[clr_r] = 1'b0;
    if (iv && ir != 0 && !exp_stall) pend_m[ir] = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    wb_we = 0; md_valid = 0; iss_valid = 0; iss_reg = 0;
    rd_reg1 = 5'd4; rd_reg2 = 5'd9;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_regwrite", {31'd0, regwrite}, 32'd0);
    check("rst_writereg", {27'd0, writereg}, 32'd0);
    check("rst_writedata", writedata, 32'd0);
    check("rst_pend_cnt", {26'd0, pend_cnt}, 32'd0);
    check("rst_md_ready", {31'd0, md_ready}, 32'd1);
    check("rst_stall", {31'd0, stall}, 32'd0);
    model_reset();
    rd_reg1 = 0; rd_reg2 = 0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("init_regwrite", {31'd0, regwrite}, 32'd0);
    check("init_pend_cnt", {26'd0, pend_cnt}, 32'd0);
    check("init_md_ready", {31'd0, md_ready}, 32'd1);
    #2;
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Plain WB write.
    step(1, 5'd5, 32'h1234_5678, 0, 0, 0, 0, 0, 0, 0);
    idle(2);

    // Collision: WB reg 3 wins, md reg 7 goes through the buffer.
    step(1, 5'd3, 32'h0000_0033, 1, 5'd7, 32'h0000_00AA, 0, 0, 0, 0);
    idle(3);

    // RAW stall on reg 9 until its md result reaches the port.
    step(0, 0, 0, 0, 0, 0, 1, 5'd9, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 5'd9, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 5'd9, 0);
    step(0, 0, 0, 1, 5'd9, 32'h9999_0009, 0, 0, 5'd9, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 5'd9, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 5'd9, 0);
    idle(2);

    // Register 0: consumed but never written, and never pending.
    step(0, 0, 0, 1, 5'd0, 32'hFFFF_FFFF, 1, 5'd0, 0, 0);
    step(1, 5'd0, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, 0);
    idle(2);

    // Re-issue to reg 6 while its previous result is on the port.
    step(0, 0, 0, 0, 0, 0, 1, 5'd6, 0, 0);
    step(0, 0, 0, 1, 5'd6, 32'h6666_0006, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 5'd6, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd6);
    #1;
    check("reissue_pend_cnt", {26'd0, pend_cnt}, 32'd1);
    // WB to a pending register writes normally and leaves it pending.
    step(1, 5'd6, 32'h0BAD_0006, 0, 0, 0, 0, 0, 5'd6, 0);
    idle(2);
    step(0, 0, 0, 1, 5'd6, 32'h6666_1106, 0, 0, 0, 0);
    idle(3);

    // Reset with a buffered md result to reg 4 still pending.
    step(0, 0, 0, 0, 0, 0, 1, 5'd4, 0, 0);
    step(1, 5'd1, 32'h1111_0001, 1, 5'd4, 32'h4444_0004, 0, 0, 0, 0);
    step(1, 5'd2, 32'h2222_0002, 0, 0, 0, 0, 0, 5'd4, 0);
    do_reset();
    step(1, 5'd8, 32'h8888_0008, 0, 0, 0, 0, 0, 5'd4, 0);
    idle(4);

    // Random traffic on a small register window to force collisions.
    for (int i = 0; i < 600; i++) begin
      logic [4:0] lim;
      lim = (i < 300) ? 5'd7 : 5'd31;
      step($urandom_range(0, 2) == 0, 5'($urandom_range(0, lim)), $urandom,
           $urandom_range(0, 2) == 0, 5'($urandom_range(0, lim)), $urandom,
           $urandom_range(0, 2) == 0, 5'($urandom_range(0, lim)),
           5'($urandom_range(0, lim)), 5'($urandom_range(0, lim)));
    end
    idle(4);
    check("drain", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
